// File: rtl/fix_seq_pkg.sv
// Shared types and helpers for the fix_seq constant-sequence stage.
// Provides table slicing and counter-width helpers.
package fix_seq_pkg;

    localparam int unsigned TBL_MAX_W  = 4096;
    localparam int unsigned TOUT_MAX_W = 256;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    function automatic logic [TOUT_MAX_W-1:0] tbl_entry(
        input logic [TBL_MAX_W-1:0] vals,
        input int unsigned          i,
        input int unsigned          tout
    );
        logic [TBL_MAX_W-1:0]  sh;
        logic [TOUT_MAX_W-1:0] mask;
        sh = vals >> (i * tout);
        if (tout >= TOUT_MAX_W) begin
            mask = {TOUT_MAX_W{1'b1}};
        end else begin
            mask = ({{(TOUT_MAX_W-1){1'b0}}, 1'b1} << tout) - {{(TOUT_MAX_W-1){1'b0}}, 1'b1};
        end
        return sh[TOUT_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/fix_seq_if.sv
// Valid/ready stream bundle used for both the token input and the beat output of fix_seq.
interface fix_seq_if #(
    parameter int unsigned W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fix_seq_oreg.sv
// Output stage of fix_seq: single register, or a 2-entry skid buffer when FIX_SEQ_SKID_EN is defined.
// The skid variant makes can_accept depend only on registered state.
module fix_seq_oreg
    import fix_seq_pkg::*;
#(
    parameter int unsigned TOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            can_accept,
    input  logic            load,
    input  logic [TOUT-1:0] load_data,
    fix_seq_if.master       dout
);

`ifdef FIX_SEQ_SKID_EN
    logic            m_vld_d, m_vld_q, s_vld_d, s_vld_q, pop_s;
    logic [TOUT-1:0] m_dat_d, m_dat_q, s_dat_d, s_dat_q;

    // Main/skid next state; a load only happens while the skid slot is empty.
    always_comb begin
        pop_s      = m_vld_q && dout.ready;
        can_accept = !s_vld_q;
        m_vld_d    = m_vld_q;
        m_dat_d    = m_dat_q;
        s_vld_d    = s_vld_q;
        s_dat_d    = s_dat_q;
        if (load) begin
            if (!m_vld_q || pop_s) begin
                m_vld_d = 1'b1;
                m_dat_d = load_data;
            end else begin
                s_vld_d = 1'b1;
                s_dat_d = load_data;
            end
        end else if (pop_s) begin
            if (s_vld_q) begin
                m_dat_d = s_dat_q;
                s_vld_d = 1'b0;
            end else begin
                m_vld_d = 1'b0;
            end
        end else begin
            m_vld_d = m_vld_q;
        end
    end

    // Main and skid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
            s_vld_q <= 1'b0;
            s_dat_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_dat_q <= m_dat_d;
            s_vld_q <= s_vld_d;
            s_dat_q <= s_dat_d;
        end
    end

    assign dout.valid = m_vld_q;
    assign dout.data  = m_dat_q;
`else
    logic            vld_d, vld_q;
    logic [TOUT-1:0] dat_d, dat_q;

    // Single register: a pop and a load on the same edge replace the value.
    always_comb begin
        can_accept = !vld_q || dout.ready;
        vld_d      = vld_q;
        dat_d      = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = load_data;
        end else if (dout.ready) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign dout.valid = vld_q;
    assign dout.data  = dat_q;
`endif

endmodule

// File: rtl/fix_seq.sv
// fix_seq: replaces each input token by REP beats taken cyclically from the constant table VALS.
// Output stage style selected by macro FIX_SEQ_SKID_EN (see fix_seq_oreg).
module fix_seq
    import fix_seq_pkg::*;
#(
    parameter int unsigned               DIN     = 1,
    parameter int unsigned               TOUT    = 8,
    parameter int unsigned               NUM_VAL = 1,
    parameter logic [NUM_VAL*TOUT-1:0]   VALS    = '0,
    parameter int unsigned               REP     = 1
) (
    input  logic      clk,
    input  logic      rst,
    fix_seq_if.slave  din,
    fix_seq_if.master dout
);

    localparam int unsigned          IDX_W    = cnt_w(NUM_VAL);
    localparam int unsigned          REP_W    = cnt_w(REP);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_VAL - 32'd1);
    localparam logic [REP_W-1:0]     REP_LAST = REP_W'(REP - 32'd1);
    localparam logic [TBL_MAX_W-1:0] VALS_EXT = TBL_MAX_W'(VALS);

    if (DIN < 32'd1 || TOUT < 32'd1 || NUM_VAL < 32'd1 || REP < 32'd1) begin : g_bad_param
        $error("fix_seq: DIN, TOUT, NUM_VAL and REP must all be at least 1");
    end
    if (NUM_VAL * TOUT > TBL_MAX_W || TOUT > TOUT_MAX_W) begin : g_bad_size
        $error("fix_seq: table exceeds fix_seq_pkg limits");
    end

    logic [IDX_W-1:0] idx_d, idx_q;
    logic [REP_W-1:0] rep_d, rep_q;
    logic             can_accept_s, load_s, last_beat_s;
    logic [TOUT-1:0]  load_data_s;

    // The token is acknowledged only together with its last beat; ready is held low in reset.
    always_comb begin
        last_beat_s = (rep_q == REP_LAST);
        load_s      = din.valid && can_accept_s;
        din.ready   = rst && can_accept_s && last_beat_s;
        load_data_s = TOUT'(tbl_entry(VALS_EXT, 32'(idx_q), TOUT));
        idx_d       = idx_q;
        rep_d       = rep_q;
        if (load_s) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1'b1);
            rep_d = last_beat_s ? '0 : rep_q + REP_W'(1'b1);
        end else begin
            idx_d = idx_q;
            rep_d = rep_q;
        end
    end

    // Table index and beat-within-token counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            rep_q <= '0;
        end else begin
            idx_q <= idx_d;
            rep_q <= rep_d;
        end
    end

    fix_seq_oreg #(
        .TOUT(TOUT)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .can_accept(can_accept_s),
        .load      (load_s),
        .load_data (load_data_s),
        .dout      (dout)
    );

endmodule

// File: tb/tb_fix_seq.sv
// Self-checking bench for fix_seq: three instances (REP=1,2,3) sharing one 3-entry table.
// Expected beats come from a beat-count model: the n-th beat after reset carries table[n mod 3].
module tb_fix_seq;

`ifdef FIX_SEQ_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid  [3];
    logic       in_data   [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic [7:0] out_data  [3];
    logic       out_ready [3];

    int         checks;
    int         errors;
    int         popped    [3];
    int         tokens    [3];
    logic       tok_done  [3];
    logic       hold      [3];
    logic [7:0] hold_dat  [3];
    logic [7:0] tbl       [3] = '{8'h10, 8'h20, 8'h30};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fix_seq_if #(.W(1)) din_if ();
        fix_seq_if #(.W(8)) dout_if ();

        assign din_if.valid  = in_valid[g];
        assign din_if.data   = in_data[g];
        assign in_ready[g]   = din_if.ready;
        assign out_valid[g]  = dout_if.valid;
        assign out_data[g]   = dout_if.data;
        assign dout_if.ready = out_ready[g];

        fix_seq #(
            .DIN    (1),
            .TOUT   (8),
            .NUM_VAL(3),
            .VALS   (24'h302010),
            .REP    (g + 1)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .din (din_if),
            .dout(dout_if)
        );
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int g = 0; g < 3; g++) begin
            popped[g]   = 0;
            tokens[g]   = 0;
            hold[g]     = 1'b0;
            tok_done[g] = 1'b0;
        end
    endtask

    // One clock cycle; called at a falling edge with inputs already set.
    task automatic tick();
        for (int g = 0; g < 3; g++) in_data[g] = 1'($urandom_range(0, 1));
        #1;
        for (int g = 0; g < 3; g++) begin
            tok_done[g] = 1'b0;
            if (out_valid[g] === 1'b1 && out_ready[g]) begin
                chk($sformatf("pop_dut%0d_beat%0d", g, popped[g]), out_data[g], tbl[popped[g] % 3]);
                popped[g]++;
            end
            hold[g]     = (out_valid[g] === 1'b1) && !out_ready[g];
            hold_dat[g] = out_data[g];
            if (in_valid[g] && in_ready[g] === 1'b1) begin
                tokens[g]++;
                tok_done[g] = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            if (hold[g]) begin
                chk($sformatf("stall_valid_dut%0d", g), out_valid[g], 1'b1);
                chk($sformatf("stall_data_dut%0d", g), out_data[g], hold_dat[g]);
            end
        end
    endtask

    task automatic drain(input int g);
        out_ready[g] = 1'b1;
        for (int c = 0; c < 8 && out_valid[g] === 1'b1; c++) tick();
        chk($sformatf("drained_dut%0d", g), out_valid[g], 1'b0);
        chk($sformatf("tokens_vs_beats_dut%0d", g), popped[g], tokens[g] * (g + 1));
    endtask

    task automatic send(input int g, input int ntok, input bit rnd);
        int acc;
        acc = 0;
        in_valid[g] = 1'b1;
        for (int c = 0; c < 4000 && acc < ntok; c++) begin
            out_ready[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (tok_done[g]) acc++;
        end
        in_valid[g] = 1'b0;
        chk($sformatf("send_tokens_dut%0d", g), acc, ntok);
        drain(g);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        reset_model();
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b1;
            in_data[g]   = 1'b0;
            out_ready[g] = 1'b1;
        end

        // Reset held with valid tokens offered: nothing may come out.
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_dout_valid", out_valid[g], 1'b0);
            chk("reset_dout_data", out_data[g], 8'h00);
            chk("reset_din_ready", in_ready[g], 1'b0);
        end
        in_valid[1] = 1'b0;
        in_valid[2] = 1'b0;
        rst = 1'b1;

        // REP=1: five tokens back to back.
        for (int k = 0; k < 5; k++) begin
            #1 chk("rep1_din_ready", in_ready[0], 1'b1);
            tick();
            chk("rep1_valid", out_valid[0], 1'b1);
            chk("rep1_data", out_data[0], tbl[k % 3]);
        end
        in_valid[0] = 1'b0;
        drain(0);
        chk("rep1_tokens", tokens[0], 5);

        // REP=2: two tokens, ready only on second beat of each.
        in_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rep2_din_ready", in_ready[1], (k % 2 == 1) ? 1'b1 : 1'b0);
            tick();
            chk("rep2_data", out_data[1], tbl[k % 3]);
        end
        in_valid[1] = 1'b0;
        drain(1);
        chk("rep2_tokens", tokens[1], 2);

        // REP=2 with random downstream stalls.
        send(1, 200, 1'b1);

        // REP=3: reset after the first beat abandons the token.
        in_valid[2] = 1'b1;
        tick();
        chk("rep3_beat1_valid", out_valid[2], 1'b1);
        chk("rep3_beat1_data", out_data[2], 8'h10);
        #1 rst = 1'b0;
        #1;
        chk("rst_pulse_valid", out_valid[2], 1'b0);
        chk("rst_pulse_data", out_data[2], 8'h00);
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("rep3_din_ready", in_ready[2], (k == 2) ? 1'b1 : 1'b0);
            tick();
            chk("rep3_data", out_data[2], tbl[k]);
        end
        in_valid[2] = 1'b0;
        drain(2);
        chk("rep3_tokens", tokens[2], 1);

        // Downstream stalled for three cycles on REP=1.
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        #1 chk("stall_din_ready0", in_ready[0], 1'b1);
        tick();
        #1 chk("stall_din_ready1", in_ready[0], SKID);
        tick();
        #1 chk("stall_din_ready2", in_ready[0], 1'b0);
        out_ready[0] = 1'b1;
        #1 chk("ready_path", in_ready[0], !SKID);
        out_ready[0] = 1'b0;
        tick();
        chk("stall_buffered", tokens[0], SKID ? 2 : 1);
        send(0, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
